// File: rtl/segment_scan_decoder.sv
// Passive readback decoder for the multiplexed 4-digit seven-segment bus.
// Optional hex glyphs (A-F) enabled by defining SEG_DECODER_HEX_EN.
module segment_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:6] segment,
    input  logic [3:0] anodes,
    input  logic       decimal_point,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] blank,
    output logic [3:0] dp,
    output logic       frame_valid,
    output logic       frame_strobe,
    output logic       decode_error,
    output logic       stale
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // {ok, blank, value}; glyph bits are abcdefg with seg a in the MSB
    function automatic logic [5:0] decode(input logic [6:0] g);
        case (g)
            7'b0000001: return {2'b10, 4'd0};
            7'b1001111: return {2'b10, 4'd1};
            7'b0010010: return {2'b10, 4'd2};
            7'b0000110: return {2'b10, 4'd3};
            7'b1001100: return {2'b10, 4'd4};
            7'b0100100: return {2'b10, 4'd5};
            7'b0100000: return {2'b10, 4'd6};
            7'b0001111: return {2'b10, 4'd7};
            7'b0000000: return {2'b10, 4'd8};
            7'b0000100: return {2'b10, 4'd9};
            7'b1111111: return {2'b11, 4'd0};
`ifdef SEG_DECODER_HEX_EN
            7'b0001000: return {2'b10, 4'd10};
            7'b1100000: return {2'b10, 4'd11};
            7'b0110001: return {2'b10, 4'd12};
            7'b1000010: return {2'b10, 4'd13};
            7'b0110000: return {2'b10, 4'd14};
            7'b0111000: return {2'b10, 4'd15};
`else
`endif
            default:    return 6'b0;
        endcase
    endfunction

    logic [11:0]      meta_q, sample_q, prev_q;
    logic [SW-1:0]    stable_cnt_q;
    logic [TW-1:0]    to_cnt_q;
    logic [3:0]       seen_q;
    logic [3:0][3:0]  sh_digit_q;
    logic [3:0]       sh_blank_q, sh_dp_q;
    logic [3:0][3:0]  digit_q;
    logic [3:0]       blank_q, dp_q;
    logic             fv_q, strobe_q, err_q, stale_q;

    logic             same, capture, onehot, legal_cap, err_cap, timeout;
    logic [3:0]       an_lo;
    logic [1:0]       idx;
    logic [5:0]       dec;

    always_comb begin
        same    = (sample_q == prev_q);
        capture = same && (stable_cnt_q == SW'(STABLE_CYCLES - 1));
        an_lo   = ~sample_q[10:7];
        onehot  = (an_lo != 4'b0) && ((an_lo & (an_lo - 4'd1)) == 4'b0);
        dec     = decode(sample_q[6:0]);
        idx     = 2'd0;
        for (int i = 0; i < 4; i++)
            if (an_lo[i]) idx = 2'(i);
        legal_cap = capture && onehot && dec[5];
        // blanking interval (no anode low) is silently ignored
        err_cap   = capture && (an_lo != 4'b0) && !(onehot && dec[5]);
        timeout   = (to_cnt_q == TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q       <= '1;
            sample_q     <= '1;
            prev_q       <= '1;
            stable_cnt_q <= '0;
            to_cnt_q     <= '0;
            seen_q       <= '0;
            sh_digit_q   <= '0;
            sh_blank_q   <= '0;
            sh_dp_q      <= '0;
            digit_q      <= '0;
            blank_q      <= '0;
            dp_q         <= '0;
            fv_q         <= 1'b0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            meta_q   <= {decimal_point, anodes, segment};
            sample_q <= meta_q;
            prev_q   <= sample_q;

            if (!same)
                stable_cnt_q <= '0;
            else if (stable_cnt_q != SW'(STABLE_CYCLES))
                stable_cnt_q <= stable_cnt_q + 1'b1;

            err_q <= err_cap;

            if (legal_cap)
                to_cnt_q <= '0;
            else if (!timeout)
                to_cnt_q <= to_cnt_q + 1'b1;

            if (legal_cap) begin
                sh_digit_q[idx] <= dec[3:0];
                sh_blank_q[idx] <= dec[4];
                sh_dp_q[idx]    <= ~sample_q[11];
                seen_q          <= ((seen_q == 4'hf) ? 4'b0 : seen_q) | (4'b1 << idx);
            end else if (seen_q == 4'hf || timeout) begin
                seen_q <= '0;
            end

            if (timeout && !legal_cap) begin
                stale_q <= 1'b1;
                fv_q    <= 1'b0;
            end

            // publish takes priority: a full frame always implies a fresh capture
            strobe_q <= (seen_q == 4'hf);
            if (seen_q == 4'hf) begin
                digit_q <= sh_digit_q;
                blank_q <= sh_blank_q;
                dp_q    <= sh_dp_q;
                fv_q    <= 1'b1;
                stale_q <= 1'b0;
            end
        end
    end

    assign digit0       = digit_q[0];
    assign digit1       = digit_q[1];
    assign digit2       = digit_q[2];
    assign digit3       = digit_q[3];
    assign blank        = blank_q;
    assign dp           = dp_q;
    assign frame_valid  = fv_q;
    assign frame_strobe = strobe_q;
    assign decode_error = err_q;
    assign stale        = stale_q;
endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: scans frames and checks published values.
module tb_segment_scan_decoder;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 2000;
    localparam int DWELL   = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:6] segment = 7'b1111111;
    logic [3:0] anodes = 4'b1111;
    logic       decimal_point = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3, blank, dp;
    logic       frame_valid, frame_strobe, decode_error, stale;

    int passed = 0, total = 0;
    int strobe_cnt = 0, err_cnt = 0;
    int s0, e0;
    logic [15:0] exp_digits;

    segment_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .segment(segment), .anodes(anodes),
        .decimal_point(decimal_point), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3), .blank(blank), .dp(dp),
        .frame_valid(frame_valid), .frame_strobe(frame_strobe),
        .decode_error(decode_error), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_strobe) strobe_cnt++;
            if (decode_error) err_cnt++;
        end
    end

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            14: return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input logic dpn, input int n);
        anodes = an;
        segment = seg;
        decimal_point = dpn;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show_digit(input int pos, input int val, input bit dp_lit);
        logic [3:0] one;
        one = 4'b0001 << pos;
        show(~one, glyph(val), ~dp_lit, DWELL);
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clk);
        #1;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h0) $display("FAIL reset_digits got %h want 0000", {digit3, digit2, digit1, digit0}); else passed++;
        total++; if ({blank, dp} !== 8'h0) $display("FAIL reset_blank_dp got %h want 00", {blank, dp}); else passed++;
        total++; if ({frame_valid, frame_strobe, decode_error, stale} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {frame_valid, frame_strobe, decode_error, stale}); else passed++;
        rst = 1'b0;
        show(4'b1111, 7'b1111111, 1'b1, 20);
    endtask

    task automatic test_scan_1234;
        s0 = strobe_cnt;
        show_digit(0, 4, 0); show_digit(1, 3, 0); show_digit(2, 2, 0);
        total++; if (strobe_cnt - s0 !== 0) $display("FAIL scan_early_strobe got %0d want 0", strobe_cnt - s0); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL scan_early_valid got %b want 0", frame_valid); else passed++;
        show_digit(3, 1, 0);
        total++; if (strobe_cnt - s0 !== 1) $display("FAIL scan_strobe got %0d want 1", strobe_cnt - s0); else passed++;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h1234) $display("FAIL scan_digits got %h want 1234", {digit3, digit2, digit1, digit0}); else passed++;
        total++; if ({frame_valid, stale, blank, dp} !== {2'b10, 8'h00}) $display("FAIL scan_flags got %b want 1000000000", {frame_valid, stale, blank, dp}); else passed++;
        exp_digits = 16'h1234;
    endtask

    task automatic test_dp;
        s0 = strobe_cnt;
        show_digit(0, 4, 0); show_digit(1, 3, 0); show_digit(2, 2, 1); show_digit(3, 1, 0);
        total++; if (strobe_cnt - s0 !== 1) $display("FAIL dp_strobe got %0d want 1", strobe_cnt - s0); else passed++;
        total++; if (dp !== 4'b0100) $display("FAIL dp_mask got %b want 0100", dp); else passed++;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h1234) $display("FAIL dp_digits got %h want 1234", {digit3, digit2, digit1, digit0}); else passed++;
    endtask

    task automatic test_glitch;
        s0 = strobe_cnt; e0 = err_cnt;
        show(4'b1110, glyph(4), 1'b1, 200);
        show(4'b1110, glyph(8), 1'b1, STABLE - 1);
        show(4'b1110, glyph(4), 1'b1, 200);
        show_digit(1, 3, 0); show_digit(2, 2, 0); show_digit(3, 1, 0);
        total++; if (err_cnt - e0 !== 0) $display("FAIL glitch_err got %0d want 0", err_cnt - e0); else passed++;
        total++; if (strobe_cnt - s0 !== 1) $display("FAIL glitch_strobe got %0d want 1", strobe_cnt - s0); else passed++;
        total++; if ({digit3, digit2, digit1, digit0, dp} !== 20'h12340) $display("FAIL glitch_frame got %h want 12340", {digit3, digit2, digit1, digit0, dp}); else passed++;
    endtask

    task automatic test_errors;
        s0 = strobe_cnt; e0 = err_cnt;
        show(4'b0011, glyph(1), 1'b1, DWELL);
        total++; if (err_cnt - e0 !== 1) $display("FAIL err_multi_anode got %0d want 1", err_cnt - e0); else passed++;
        show_digit(0, 14, 0);
        show_digit(1, 3, 0); show_digit(2, 2, 0); show_digit(3, 1, 0);
`ifdef SEG_DECODER_HEX_EN
        total++; if (err_cnt - e0 !== 1) $display("FAIL err_hex_count got %0d want 1", err_cnt - e0); else passed++;
        total++; if (strobe_cnt - s0 !== 1) $display("FAIL err_hex_strobe got %0d want 1", strobe_cnt - s0); else passed++;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h123E) $display("FAIL err_hex_digits got %h want 123e", {digit3, digit2, digit1, digit0}); else passed++;
        exp_digits = 16'h123E;
`else
        total++; if (err_cnt - e0 !== 2) $display("FAIL err_illegal_count got %0d want 2", err_cnt - e0); else passed++;
        total++; if (strobe_cnt - s0 !== 0) $display("FAIL err_no_strobe got %0d want 0", strobe_cnt - s0); else passed++;
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h1234) $display("FAIL err_digits_hold got %h want 1234", {digit3, digit2, digit1, digit0}); else passed++;
`endif
    endtask

    task automatic test_stale;
        show(4'b1111, 7'b1111111, 1'b1, 100);
        total++; if (stale !== 1'b0) $display("FAIL stale_early got %b want 0", stale); else passed++;
        show(4'b1111, 7'b1111111, 1'b1, TIMEOUT + 100);
        total++; if ({stale, frame_valid} !== 2'b10) $display("FAIL stale_flags got %b want 10", {stale, frame_valid}); else passed++;
        total++; if ({digit3, digit2, digit1, digit0} !== exp_digits) $display("FAIL stale_hold got %h want %h", {digit3, digit2, digit1, digit0}, exp_digits); else passed++;
        s0 = strobe_cnt;
        show_digit(0, 5, 0); show_digit(1, 6, 0);
        total++; if (stale !== 1'b1) $display("FAIL stale_midscan got %b want 1", stale); else passed++;
        show_digit(2, 7, 0); show_digit(3, 16, 0);
        total++; if ({stale, frame_valid, strobe_cnt - s0} !== {2'b01, 32'd1}) $display("FAIL stale_resume got %b/%0d want 01/1", {stale, frame_valid}, strobe_cnt - s0); else passed++;
        total++; if ({digit3, digit2, digit1, digit0, blank} !== 20'h07658) $display("FAIL stale_resume_frame got %h want 07658", {digit3, digit2, digit1, digit0, blank}); else passed++;
    endtask

    task automatic test_reset_midframe;
        show_digit(0, 9, 0); show_digit(1, 9, 0);
        rst = 1'b1;
        show(4'b1111, 7'b1111111, 1'b1, 3);
        total++; if ({frame_valid, digit3, digit2, digit1, digit0} !== 17'h0) $display("FAIL rst_mid_clear got %h want 00000", {frame_valid, digit3, digit2, digit1, digit0}); else passed++;
        rst = 1'b0;
        show(4'b1111, 7'b1111111, 1'b1, 20);
        s0 = strobe_cnt;
        show_digit(0, 4, 0); show_digit(1, 3, 0); show_digit(2, 2, 0);
        total++; if (strobe_cnt - s0 !== 0) $display("FAIL rst_mid_early got %0d want 0", strobe_cnt - s0); else passed++;
        show_digit(3, 1, 0);
        total++; if (strobe_cnt - s0 !== 1) $display("FAIL rst_mid_strobe got %0d want 1", strobe_cnt - s0); else passed++;
        total++; if ({frame_valid, digit3, digit2, digit1, digit0} !== 17'h11234) $display("FAIL rst_mid_frame got %h want 11234", {frame_valid, digit3, digit2, digit1, digit0}); else passed++;
    endtask

    initial begin
        exp_digits = 16'h0;
        test_reset;
        test_scan_1234;
        test_dp;
        test_glitch;
        test_errors;
        test_stale;
        test_reset_midframe;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
